forwarding_hazard_unit: RTL
===========================

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 Parameter NUM_READ_PORTS, default 2, number of source-operand ports checked per ID instruction (1..4).
REQ-002 Parameter NUM_STAGES, default 2, number of tracked producer stages after ID (stage 1 = EX, stage 2 = MEM, ...; 1..4).
REQ-003 Parameter REG_ADDR_W, default 5, register address width.
REQ-004 Parameter CNT_W, default 32, stall counter width.
REQ-005 Derived constant FWD_CODE_W = clog2(2*NUM_STAGES+1), per-port forward code width.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 id_valid  input  1  ID holds a real instruction.
REQ-009 id_rs_addr  input  NUM_READ_PORTS*REG_ADDR_W  source registers; port p at bits [p*REG_ADDR_W +: REG_ADDR_W].
REQ-010 id_rs_used  input  NUM_READ_PORTS  bit p set = port p is actually read.
REQ-011 id_rd_addr  input  REG_ADDR_W  destination register of ID instruction.
REQ-012 id_reg_write  input  1  ID instruction writes rd.
REQ-013 id_mem_to_reg  input  1  ID instruction is a load (result available only after the memory stage).
REQ-014 pipe_freeze  input  1  whole pipeline holds (e.g. memory busy).
REQ-015 flush  input  1  ID instruction squashed (taken branch/jump).
REQ-016 fwd_sel  output  NUM_READ_PORTS*FWD_CODE_W  per-port forward code, combinational.
REQ-017 stall  output  1  load-use stall request to PC/IF/ID, combinational.
REQ-018 stall_count  output  CNT_W  registered count of load-use stall cycles.

Function
REQ-019 Unit SHALL keep a tag pipeline of NUM_STAGES entries {valid, rd, wr, load}; entry s mirrors the instruction in stage s.
REQ-020 Entry s SHALL be "producing for r" when valid && wr && rd != 0 && rd == r.
REQ-021 Forward codes SHALL be: 0 = register file; 2s-1 = stage s ALU result; 2s = stage s memory result.
REQ-022 For port p with id_rs_used[p]=1, fwd_sel[p] SHALL select the lowest-numbered (youngest) stage producing for id_rs_addr[p]; code 2s if that entry has load=1, else 2s-1; older matches ignored.
REQ-023 fwd_sel[p] SHALL be 0 when id_rs_used[p]=0, id_rs_addr[p]=0, id_valid=0, or no stage matches.
REQ-024 Load-use hazard SHALL exist when id_valid=1 and any used port's youngest match is stage 1 with load=1; that port's fwd_sel SHALL then be 0.
REQ-025 stall SHALL equal load-use hazard && !flush && !pipe_freeze.
REQ-026 Advance rule, priority order at each edge: reset > pipe_freeze > flush > stall > normal.
REQ-027 pipe_freeze=1: all entries hold; stall_count holds.
REQ-028 flush=1 (no freeze): entry 1 <= bubble (valid=0), entries s>1 <= entry s-1.
REQ-029 stall=1: entry 1 <= bubble, entries s>1 <= entry s-1, stall_count increments by 1.
REQ-030 Normal: entry 1 <= {id_valid, id_rd_addr, id_reg_write, id_mem_to_reg}, entries s>1 <= entry s-1; oldest entry discarded.
REQ-031 stall_count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-032 Stall SHALL last exactly 1 cycle per load-use pair when NUM_STAGES>=2 (load reaches stage 2, code 4 selected next cycle).
REQ-033 Simultaneous flush and hazard: flush wins, no stall, no count increment.

Reset
REQ-034 On reset=1 at an edge, all entries SHALL become invalid and stall_count SHALL become 0; fwd_sel all 0 and stall 0 follow from the cleared state for every input combination.
REQ-035 Reset mid-stall or mid-freeze SHALL discard all pending tags; no forwarding from pre-reset instructions afterwards.

Verification
REQ-036 add x5 (wr=1,load=0) then ID reads rs0=x5 -> cycle after issue fwd_sel[0]=1, stall=0; following cycle (x5 in MEM) code 3.
REQ-037 lw x6 then ID reads rs1=x6 -> stall=1 one cycle, fwd_sel[1]=0, stall_count 0->1; next cycle stall=0, fwd_sel[1]=4.
REQ-038 x7 written in stage 2 (ALU) and stage 1 (ALU), ID reads x7 on both ports -> both fwd_sel=1 (youngest wins).
REQ-039 rd=x0 with wr=1 in stage 1, ID reads x0 -> fwd_sel=0; load-use to x0 -> stall=0.
REQ-040 lw x6 in stage 1, ID reads x6, flush=1 same cycle -> stall=0, count unchanged; pipe_freeze=1 for 3 cycles -> tags and fwd_sel stable.
REQ-041 Reset asserted while stall=1 -> next cycle stall=0, stall_count=0, all fwd_sel=0.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding selector and load-use stall generator for an in-order pipeline.
// A small tag pipeline mirrors the destination of each instruction downstream of ID.
module forwarding_hazard_unit #(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_STAGES     = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 32,
  localparam int FWD_CODE_W    = $clog2(2 * NUM_STAGES + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               id_valid,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_READ_PORTS-1:0]          id_rs_used,
  input  logic [REG_ADDR_W-1:0]              id_rd_addr,
  input  logic                               id_reg_write,
  input  logic                               id_mem_to_reg,
  input  logic                               pipe_freeze,
  input  logic                               flush,
  output logic [NUM_READ_PORTS*FWD_CODE_W-1:0] fwd_sel,
  output logic                               stall,
  output logic [CNT_W-1:0]                   stall_count
);

  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [FWD_CODE_W-1:0] CODE_RF  = {FWD_CODE_W{1'b0}};

  // Index 0 is stage 1 (EX), index NUM_STAGES-1 is the oldest tracked stage.
  logic [NUM_STAGES-1:0]                 tag_valid_r;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] tag_rd_r;
  logic [NUM_STAGES-1:0]                 tag_wr_r;
  logic [NUM_STAGES-1:0]                 tag_load_r;
  logic [CNT_W-1:0]                      stall_count_r;

  logic [NUM_READ_PORTS-1:0] port_hazard_s;
  logic                      hazard_s;
  logic                      stall_s;

  function automatic logic is_producer(
    input logic                  valid,
    input logic                  wr,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return valid && wr && (rd != REG_ZERO) && (rd == rs);
  endfunction

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic [REG_ADDR_W-1:0] rs_s;
    logic                  port_live_s;
    logic                  found_s;
    logic                  match_load1_s;
    logic [FWD_CODE_W-1:0] match_code_s;

    assign rs_s        = id_rs_addr[p*REG_ADDR_W +: REG_ADDR_W];
    assign port_live_s = id_valid && id_rs_used[p] && (rs_s != REG_ZERO);

    // Youngest producing stage wins; older matches are shadowed.
    always_comb begin
      found_s       = 1'b0;
      match_load1_s = 1'b0;
      match_code_s  = CODE_RF;
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (!found_s && is_producer(tag_valid_r[s], tag_wr_r[s], tag_rd_r[s], rs_s)) begin
          found_s       = 1'b1;
          match_code_s  = tag_load_r[s] ? FWD_CODE_W'(2 * s + 2) : FWD_CODE_W'(2 * s + 1);
          match_load1_s = (s == 0) && tag_load_r[s];
        end else begin
          found_s = found_s;
        end
      end
    end

    // A load still in EX cannot be forwarded; the port reads the register file while stalled.
    assign port_hazard_s[p] = port_live_s && match_load1_s;
    assign fwd_sel[p*FWD_CODE_W +: FWD_CODE_W] =
      (port_live_s && !match_load1_s) ? match_code_s : CODE_RF;
  end

  assign hazard_s    = |port_hazard_s;
  assign stall_s     = hazard_s && !flush && !pipe_freeze;
  assign stall       = stall_s;
  assign stall_count = stall_count_r;

  // Tag pipeline advance and stall counter: reset > freeze > flush/stall bubble > normal.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_r   <= {NUM_STAGES{1'b0}};
      tag_rd_r      <= {(NUM_STAGES*REG_ADDR_W){1'b0}};
      tag_wr_r      <= {NUM_STAGES{1'b0}};
      tag_load_r    <= {NUM_STAGES{1'b0}};
      stall_count_r <= {CNT_W{1'b0}};
    end else if (pipe_freeze) begin
      tag_valid_r   <= tag_valid_r;
      tag_rd_r      <= tag_rd_r;
      tag_wr_r      <= tag_wr_r;
      tag_load_r    <= tag_load_r;
      stall_count_r <= stall_count_r;
    end else begin
      for (int s = 1; s < NUM_STAGES; s++) begin
        tag_valid_r[s] <= tag_valid_r[s-1];
        tag_rd_r[s]    <= tag_rd_r[s-1];
        tag_wr_r[s]    <= tag_wr_r[s-1];
        tag_load_r[s]  <= tag_load_r[s-1];
      end
      if (flush || stall_s) begin
        tag_valid_r[0] <= 1'b0;
        tag_rd_r[0]    <= REG_ZERO;
        tag_wr_r[0]    <= 1'b0;
        tag_load_r[0]  <= 1'b0;
      end else begin
        tag_valid_r[0] <= id_valid;
        tag_rd_r[0]    <= id_rd_addr;
        tag_wr_r[0]    <= id_reg_write;
        tag_load_r[0]  <= id_mem_to_reg;
      end
      if (stall_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_ONE;
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

endmodule
